// File: rtl/egg_timer_ctrl.sv
// Egg-timer control FSM: SET/RUN/PAUSE/DONE sequencing with edge-detected buttons
// and one-cycle datapath command pulses. All outputs are registered.
module egg_timer_ctrl #(
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cook_time,
  input  logic       start,
  input  logic       minutes,
  input  logic       seconds,
  input  logic       tick_1hz,
  input  logic       cnt_zero,
  output logic       clr,
  output logic       inc_min,
  output logic       inc_sec,
  output logic       dec_en,
  output logic [2:0] z,
  output logic       timer_enabled,
  output logic       alarm
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

  state_t     state, state_next;
  logic       start_q, minutes_q, seconds_q;
  logic       start_edge, minutes_edge, seconds_edge;
  logic [7:0] alarm_cnt, alarm_cnt_next;
  logic       clr_next, inc_min_next, inc_sec_next, dec_en_next;

  // History resets high so a button held through reset needs a fresh press.
  assign start_edge   = start   & ~start_q;
  assign minutes_edge = minutes & ~minutes_q;
  assign seconds_edge = seconds & ~seconds_q;

  assign z = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      clr           <= 1'b0;
      inc_min       <= 1'b0;
      inc_sec       <= 1'b0;
      dec_en        <= 1'b0;
      timer_enabled <= 1'b0;
      alarm         <= 1'b0;
      alarm_cnt     <= 8'd0;
      start_q       <= 1'b1;
      minutes_q     <= 1'b1;
      seconds_q     <= 1'b1;
    end else begin
      state         <= state_next;
      clr           <= clr_next;
      inc_min       <= inc_min_next;
      inc_sec       <= inc_sec_next;
      dec_en        <= dec_en_next;
      timer_enabled <= (state_next == RUN);
      alarm         <= (state_next == DONE);
      alarm_cnt     <= alarm_cnt_next;
      start_q       <= start;
      minutes_q     <= minutes;
      seconds_q     <= seconds;
    end
  end

  always_comb begin
    state_next     = state;
    clr_next       = 1'b0;
    inc_min_next   = 1'b0;
    inc_sec_next   = 1'b0;
    dec_en_next    = 1'b0;
    alarm_cnt_next = alarm_cnt;
    if (!enable) begin
      state_next = IDLE;
      clr_next   = (state != IDLE);
    end else begin
      case (state)
        IDLE: begin
          if (cook_time) begin
            state_next = SET;
            clr_next   = 1'b1;
          end
        end
        SET: begin
          if (!cook_time) begin
            state_next = IDLE;
            clr_next   = 1'b1;
          end else if (start_edge) begin
            // A start press on a zero time is swallowed without effect.
            if (!cnt_zero) state_next = RUN;
          end else begin
            inc_min_next = minutes_edge;
            inc_sec_next = seconds_edge;
          end
        end
        RUN: begin
          if (!cook_time) begin
            state_next = IDLE;
            clr_next   = 1'b1;
          end else if (start_edge) begin
            state_next = PAUSE;
          end else if (tick_1hz) begin
            if (cnt_zero) begin
              state_next     = DONE;
              alarm_cnt_next = 8'd0;
            end else begin
              dec_en_next = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (!cook_time) begin
            state_next = IDLE;
            clr_next   = 1'b1;
          end else if (start_edge) begin
            state_next = RUN;
          end
        end
        DONE: begin
          if (start_edge) begin
            state_next = IDLE;
          end else if (tick_1hz) begin
            if (alarm_cnt == ALARM_LAST) state_next = IDLE;
            else alarm_cnt_next = alarm_cnt + 8'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl: directed button/tick sequences, a per-cycle reference
// model of the timer rules, and literal pulse-count and state checks.
module tb_egg_timer_ctrl;

  localparam int ALARM_TICKS = 10;

  logic       clk = 1'b0;
  logic       reset, enable, cook_time, start, minutes, seconds, tick_1hz, cnt_zero;
  logic       clr, inc_min, inc_sec, dec_en, timer_enabled, alarm;
  logic [2:0] z;

  int checks = 0;
  int errors = 0;

  int n_inc_min = 0, n_inc_sec = 0, n_dec_en = 0, n_clr = 0;

  egg_timer_ctrl #(.ALARM_TICKS(ALARM_TICKS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cook_time(cook_time),
    .start(start), .minutes(minutes), .seconds(seconds), .tick_1hz(tick_1hz),
    .cnt_zero(cnt_zero), .clr(clr), .inc_min(inc_min), .inc_sec(inc_sec),
    .dec_en(dec_en), .z(z), .timer_enabled(timer_enabled), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Reference model: mode code plus alarm ticks still to go.
  int m_mode = 0;
  int m_left = 0;
  bit m_clr, m_im, m_is, m_de;
  bit p_start = 1, p_min = 1, p_sec = 1;

  task automatic model_step();
    bit se, me, ze;
    se = start && !p_start;
    me = minutes && !p_min;
    ze = seconds && !p_sec;
    m_clr = 0; m_im = 0; m_is = 0; m_de = 0;
    if (reset) begin
      m_mode = 0; m_left = 0;
      p_start = 1; p_min = 1; p_sec = 1;
      return;
    end
    if (!enable) begin
      m_clr = (m_mode != 0); m_mode = 0;
    end else if (m_mode == 0) begin
      if (cook_time) begin m_mode = 1; m_clr = 1; end
    end else if (m_mode == 4) begin
      if (se) m_mode = 0;
      else if (tick_1hz) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 0;
      end
    end else if (!cook_time) begin
      m_mode = 0; m_clr = 1;
    end else if (se) begin
      if (m_mode == 1) begin
        if (!cnt_zero) m_mode = 2;
      end else m_mode = (m_mode == 2) ? 3 : 2;
    end else if (tick_1hz && m_mode == 2) begin
      if (cnt_zero) begin m_mode = 4; m_left = ALARM_TICKS; end
      else m_de = 1;
    end else if (m_mode == 1) begin
      m_im = me; m_is = ze;
    end
    p_start = start; p_min = minutes; p_sec = seconds;
  endtask

  initial begin
    logic [8:0] act, exp;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      act = {z, clr, inc_min, inc_sec, dec_en, timer_enabled, alarm};
      exp = {3'(m_mode), m_clr, m_im, m_is, m_de, (m_mode == 2), (m_mode == 4)};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model t=%0t {z,clr,im,is,de,te,al} got %b expected %b", $time, act, exp);
      end
      n_inc_min += int'(inc_min);
      n_inc_sec += int'(inc_sec);
      n_dec_en  += int'(dec_en);
      n_clr     += int'(clr);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // which: 0=start 1=minutes 2=seconds
  task automatic press(input int which);
    case (which)
      0: start = 1'b1;
      1: minutes = 1'b1;
      default: seconds = 1'b1;
    endcase
    cyc(2);
    start = 1'b0; minutes = 1'b0; seconds = 1'b0;
    cyc(2);
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
    cyc(2);
  endtask

  initial begin
    int b_min, b_sec, b_dec, b_clr;
    reset = 1; enable = 0; cook_time = 0; start = 0; minutes = 0; seconds = 0;
    tick_1hz = 0; cnt_zero = 0;
    cyc(5);
    check("reset_z", int'(z), 0);
    check("reset_pulses", int'({clr, inc_min, inc_sec, dec_en, timer_enabled, alarm}), 0);

    reset = 0; enable = 1; cook_time = 1;
    b_clr = n_clr;
    cyc(1);
    check("enter_set_z", int'(z), 1);
    check("enter_set_clr", int'(clr), 1);
    cyc(2);
    check("set_single_clr", n_clr - b_clr, 1);

    b_min = n_inc_min; b_sec = n_inc_sec;
    repeat (3) press(1);
    repeat (2) press(2);
    check("inc_min_count", n_inc_min - b_min, 3);
    check("inc_sec_count", n_inc_sec - b_sec, 2);

    cnt_zero = 1;
    press(0);
    check("start_on_zero_stays_set", int'(z), 1);

    cnt_zero = 0;
    press(0);
    check("run_z", int'(z), 2);
    check("run_timer_enabled", int'(timer_enabled), 1);
    b_dec = n_dec_en;
    repeat (4) tick();
    check("four_dec_en", n_dec_en - b_dec, 4);
    cnt_zero = 1;
    tick();
    check("done_z", int'(z), 4);
    check("done_alarm", int'(alarm), 1);
    check("no_fifth_dec_en", n_dec_en - b_dec, 4);

    repeat (8) tick();
    tick_1hz = 1; cyc(1); tick_1hz = 0;
    check("alarm_after_9_ticks", int'(alarm), 1);
    cyc(2);
    tick_1hz = 1; cyc(1); tick_1hz = 0;
    check("idle_after_10_ticks", int'(z), 0);
    check("alarm_off_after_10", int'(alarm), 0);
    cyc(2);
    check("auto_reenter_set", int'(z), 1);

    cnt_zero = 0;
    press(0);
    cnt_zero = 1;
    tick();
    check("done_again", int'(z), 4);
    repeat (2) tick();
    start = 1; cyc(1);
    check("ack_to_idle", int'(z), 0);
    start = 0; cyc(2);

    cnt_zero = 0;
    press(0);
    b_dec = n_dec_en;
    start = 1; tick_1hz = 1; cyc(1); tick_1hz = 0;
    check("pause_wins_z", int'(z), 3);
    check("pause_wins_no_dec", int'(dec_en), 0);
    cyc(1); start = 0; cyc(1);
    repeat (3) tick();
    check("pause_no_dec", n_dec_en - b_dec, 0);
    start = 1; cyc(1);
    check("resume_run", int'(z), 2);
    start = 0; cyc(2);

    cook_time = 0; cyc(1);
    check("cook_off_idle", int'(z), 0);
    check("cook_off_clr", int'(clr), 1);
    cyc(2);
    cook_time = 1; cyc(2);
    press(0);
    press(0);
    check("paused_again", int'(z), 3);
    enable = 0; cyc(1);
    check("enable_off_idle", int'(z), 0);
    check("enable_off_clr", int'(clr), 1);
    cyc(2);

    enable = 1; start = 1; reset = 1;
    cyc(2);
    reset = 0;
    cyc(4);
    check("held_start_no_run", int'(z), 1);
    start = 0; cyc(1);
    start = 1; cyc(1);
    check("repress_runs", int'(z), 2);
    start = 0; cyc(2);
    reset = 1; cyc(1);
    check("reset_mid_run_z", int'(z), 0);
    check("reset_mid_run_te", int'(timer_enabled), 0);
    reset = 0; cyc(2);
    press(0);
    cnt_zero = 1; tick();
    reset = 1; cyc(1);
    check("reset_mid_done_alarm", int'(alarm), 0);
    reset = 0; cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/egg_timer_ctrl.md
EGG_TIMER_CTRL -- requirements
Module: egg_timer_ctrl

Interface
REQ-001 Parameter ALARM_TICKS, default 10: number of tick_1hz pulses the alarm stays asserted in DONE; legal range 1-255.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 enable  in  1  master enable level; low forces IDLE.
REQ-005 cook_time  in  1  set-mode level; high permits entry to and residence in SET/RUN/PAUSE.
REQ-006 start  in  1  start/pause/acknowledge button, level, edge-detected internally.
REQ-007 minutes  in  1  minute-increment button, level, edge-detected internally.
REQ-008 seconds  in  1  second-increment button, level, edge-detected internally.
REQ-009 tick_1hz  in  1  one-cycle pulse from prescaler, once per second.
REQ-010 cnt_zero  in  1  datapath flag: loaded time equals 00:00.
REQ-011 clr  out  1  one-cycle datapath clear pulse.
REQ-012 inc_min  out  1  one-cycle minute-increment pulse to datapath.
REQ-013 inc_sec  out  1  one-cycle second-increment pulse to datapath.
REQ-014 dec_en  out  1  one-cycle countdown-by-one-second pulse to datapath.
REQ-015 z  out  3  state code: IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4.
REQ-016 timer_enabled  out  1  high exactly while z==RUN.
REQ-017 alarm  out  1  high exactly while z==DONE.

Function
REQ-018 All outputs registered; a response is visible the cycle after the input sample that causes it.
REQ-019 Edge detect: edge on X in cycle N when X==1 in N and X==0 in N-1; one pulse per press regardless of hold length.
REQ-020 IDLE: enable & cook_time -> SET, clr=1 for the first SET cycle.
REQ-021 SET: minutes edge -> inc_min=1 one cycle; seconds edge -> inc_sec=1 one cycle; both same cycle -> both pulses same cycle.
REQ-022 SET: start edge & !cnt_zero -> RUN; start edge & cnt_zero -> remain SET, no output change.
REQ-023 RUN: tick_1hz & !cnt_zero -> dec_en=1 one cycle, remain RUN.
REQ-024 RUN: tick_1hz & cnt_zero -> DONE, no dec_en pulse.
REQ-025 RUN: start edge -> PAUSE; start edge and tick_1hz same cycle -> PAUSE wins, tick dropped, no dec_en.
REQ-026 PAUSE: tick_1hz ignored; start edge -> RUN; minutes/seconds edges ignored in RUN, PAUSE, DONE.
REQ-027 SET/RUN/PAUSE: cook_time==0 -> IDLE, clr=1 for one cycle; overrides start and tick_1hz.
REQ-028 DONE: 8-bit alarm counter cleared on entry, incremented per tick_1hz; after ALARM_TICKS ticks -> IDLE.
REQ-029 DONE: start edge -> IDLE immediately (acknowledge); cook_time ignored in DONE.
REQ-030 Any state: enable==0 -> IDLE next cycle, highest priority below reset; clr=1 one cycle if leaving non-IDLE.
REQ-031 Priority per cycle: reset > enable low > cook_time low > start edge > tick_1hz > minutes/seconds edges.
REQ-032 Undefined z codes (5-7) -> IDLE next cycle.

Reset
REQ-033 reset==1 -> z=IDLE, clr=inc_min=inc_sec=dec_en=timer_enabled=alarm=0, alarm counter=0.
REQ-034 Edge-detect history registers reset to 1: a button held through reset gives no edge until released and re-pressed.
REQ-035 reset asserted mid-RUN or mid-DONE aborts immediately; no pulse outputs in the cycle after reset.

Verification
REQ-036 reset 5 cycles, enable=1, cook_time=1 -> z=1 with one clr pulse; 3 minutes presses, 2 seconds presses -> exactly 3 inc_min, 2 inc_sec pulses.
REQ-037 SET, cnt_zero=0, start press -> z=2; 4 ticks -> 4 dec_en; cnt_zero=1 then tick -> z=4, alarm=1, no 5th dec_en.
REQ-038 RUN, start edge coincident with tick -> z=3, no dec_en; 3 ticks in PAUSE -> no dec_en; start press -> z=2.
REQ-039 DONE with ALARM_TICKS=10 -> alarm high through 10 ticks, z=0 the cycle after 10th tick; repeat with start press after 2 ticks -> z=0 next cycle.
REQ-040 RUN, cook_time->0 -> z=0 with one clr pulse; separately enable->0 from PAUSE -> z=0, clr pulse.
REQ-041 SET, cnt_zero=1, start press -> z stays 1; start held high across reset -> no RUN entry until re-pressed.
